// File: rtl/truth_table_pkg.sv
// Shared types and constants for truth-table sweepers: FSM states, row count,
// row-to-bit mapping and common 3-input gate IDs (row 000 in bit 7).
package truth_table_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  localparam int unsigned ROWS = 8;

  localparam logic [7:0] ID_0x6B = 8'h6B;
  localparam logic [7:0] ID_AND3 = 8'h01;
  localparam logic [7:0] ID_OR3  = 8'h7F;
  localparam logic [7:0] ID_XOR3 = 8'h69;

  // Row 000 lands in bit 7, row 111 in bit 0.
  function automatic logic [2:0] row_bit(input logic [2:0] row);
    return 3'(ROWS - 1) - row;
  endfunction

endpackage

// File: rtl/truth_table_sweeper_sync_2ff.sv
// Two-flop synchronizer for the gate output; both stages reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Walks a 3-input gate through all 8 rows, captures its truth table and
// compares it with EXPECTED. Define SWEEP_SYNC_EN to synchronize gate_out.
module truth_table_sweeper
  import truth_table_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter logic [7:0]  EXPECTED      = ID_0x6B
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       gate_out,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  output logic       busy,
  output logic       done,
  output logic [7:0] table_out,
  output logic       match
);

  localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYCLES - 1);

  logic sample;

`ifdef SWEEP_SYNC_EN
  localparam int unsigned MIN_SETTLE = 3;
  sync_2ff u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (gate_out),
    .q    (sample)
  );
`else
  localparam int unsigned MIN_SETTLE = 1;
  assign sample = gate_out;
`endif

  if (SETTLE_CYCLES < MIN_SETTLE || SETTLE_CYCLES > 65535) begin : g_bad_settle
    $error("truth_table_sweeper: SETTLE_CYCLES out of range");
  end

  state_e           state_q, state_d;
  logic [2:0]       row_q, row_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       shadow_q, shadow_d;
  logic [2:0]       ins_q, ins_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [7:0]       table_q, table_d;
  logic             match_q, match_d;

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    ins_d    = ins_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    table_d  = table_q;
    match_d  = match_q;
    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d  = RUN;
          row_d    = '0;
          cnt_d    = RELOAD;
          shadow_d = '0;
          ins_d    = '0;
          busy_d   = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          ins_d   = '0;
          busy_d  = 1'b0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          shadow_d[row_bit(row_q)] = sample;
          if (row_q == 3'(ROWS - 1)) begin
            // Outputs are registered, so publish the table as we enter DONE.
            state_d = DONE;
            ins_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            table_d = shadow_d;
            match_d = (shadow_d == EXPECTED);
          end else begin
            row_d = row_q + 3'd1;
            cnt_d = RELOAD;
            ins_d = row_q + 3'd1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      row_q    <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      ins_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      table_q  <= '0;
      match_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      ins_q    <= ins_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      table_q  <= table_d;
      match_q  <= match_d;
    end
  end

  assign {in1, in2, in3} = ins_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign table_out       = table_q;
  assign match           = match_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: a behavioural 3-input gate driven by the
// sweeper, table-driven and random gate functions, plus abort/reset corners.
module tb_truth_table_sweeper;

  localparam int unsigned S     = 4;
  localparam int unsigned SWEEP = 8 * S;
  localparam logic [7:0]  EXP   = 8'h6B;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       gate_out;
  logic       in1, in2, in3, busy, done, match;
  logic [7:0] table_out;
  logic [7:0] gate_id = 8'h00;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Gate under test: the output for input row r is the function's entry for r,
  // where row 000 is the most significant bit of the gate ID.
  function automatic logic gate_fn(input logic [7:0] id, input int r);
    return id[7 - r];
  endfunction

  assign gate_out = gate_fn(gate_id, int'({in1, in2, in3}));

  // Reference: what a sweep must measure for a given gate function.
  function automatic logic [7:0] ref_table(input logic [7:0] id);
    logic [7:0] t;
    t = '0;
    for (int r = 0; r < 8; r++) t[7 - r] = gate_fn(id, r);
    return t;
  endfunction

  truth_table_sweeper #(
    .SETTLE_CYCLES(S),
    .EXPECTED     (EXP)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .gate_out (gate_out),
    .in1      (in1),
    .in2      (in2),
    .in3      (in3),
    .busy     (busy),
    .done     (done),
    .table_out(table_out),
    .match    (match)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string name, input logic [7:0] tab, input logic m);
    check({name, "_ins"}, 32'({in1, in2, in3}), 32'd0);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_done"}, 32'(done), 32'd0);
    check({name, "_table"}, 32'(table_out), 32'(tab));
    check({name, "_match"}, 32'(match), 32'(m));
  endtask

  // One full sweep; optional extra start pulse at cycle poke_at (0 = none).
  task automatic sweep(input string tag, input logic [7:0] id, input int poke_at);
    int rows_err = 0;
    int ndone = 0;
    int first_done = -1;
    logic [7:0] tab_at_done = 'x;
    logic m_at_done = 1'bx;
    logic [7:0] exp_tab;
    exp_tab = ref_table(id);
    gate_id = id;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= int'(SWEEP) + 4; k++) begin
      @(negedge clk);
      if (k <= int'(SWEEP)) begin
        if (busy !== 1'b1 || {in1, in2, in3} !== 3'((k - 1) / int'(S))) rows_err++;
      end else if (k == int'(SWEEP) + 1) begin
        if (busy !== 1'b0 || {in1, in2, in3} !== 3'd0) rows_err++;
      end
      if (done === 1'b1) begin
        ndone++;
        if (first_done < 0) begin
          first_done  = k;
          tab_at_done = table_out;
          m_at_done   = match;
        end
      end
      if (k == poke_at) begin
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
      end
    end
    check({tag, "_rows"}, 32'(rows_err), 32'd0);
    check({tag, "_ndone"}, 32'(ndone), 32'd1);
    check({tag, "_latency"}, 32'(first_done), 32'(SWEEP + 1));
    check({tag, "_table"}, 32'(tab_at_done), 32'(exp_tab));
    check({tag, "_match"}, 32'(m_at_done), 32'(exp_tab == EXP));
    check({tag, "_table_hold"}, 32'(table_out), 32'(exp_tab));
  endtask

  typedef struct {
    string      name;
    logic [7:0] id;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int cnt_busy;
    int cnt_done;
    logic [7:0] rid;

    vecs.push_back('{"v_6b", 8'h6B});
    vecs.push_back('{"v_stuck1", 8'hFF});
    vecs.push_back('{"v_6b_again", 8'h6B});
    vecs.push_back('{"v_stuck0", 8'h00});
    vecs.push_back('{"v_xor3", 8'h69});
    vecs.push_back('{"v_6a", 8'h6A});
    vecs.push_back('{"v_eb", 8'hEB});
    for (int i = 0; i < 5; i++) begin
      rid = 8'($urandom);
      vecs.push_back('{$sformatf("rnd%0d_%02h", i, rid), rid});
    end

    // Reset, then idle with no start.
    repeat (2) @(negedge clk);
    check_idle_outputs("in_reset", 8'h00, 1'b0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("idle", 8'h00, 1'b0);

    foreach (vecs[i]) sweep(vecs[i].name, vecs[i].id, 0);

    sweep("pre_abort", 8'h6B, 0);

    // Abort once row 3 is on the inputs; previous result must survive.
    gate_id = 8'hFF;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3 * S + 1) @(negedge clk);
    check("abort_row3", 32'({in1, in2, in3}), 32'd3);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    check_idle_outputs("after_abort", 8'h6B, 1'b1);
    cnt_busy = 0;
    cnt_done = 0;
    repeat (SWEEP + 4) begin
      @(negedge clk);
      if (busy === 1'b1) cnt_busy++;
      if (done === 1'b1) cnt_done++;
    end
    check("abort_no_busy", 32'(cnt_busy), 32'd0);
    check("abort_no_done", 32'(cnt_done), 32'd0);

    // start together with abort in IDLE: nothing happens.
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1 begin start = 1'b0; abort = 1'b0; end
    cnt_busy = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy !== 1'b0) cnt_busy++;
    end
    check("start_abort_idle", 32'(cnt_busy), 32'd0);

    // Extra start mid-sweep must not stretch or repeat the sweep.
    sweep("midstart", 8'h6B, 10);

    // Asynchronous reset during row 5.
    gate_id = 8'h6B;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5 * S + 1) @(negedge clk);
    check("rst_row5", 32'({in1, in2, in3}), 32'd5);
    #1 rst_n = 1'b0;
    #1 check_idle_outputs("async_rst", 8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    sweep("after_rst", 8'h6B, 0);

    // Random gate functions, including random extra start pokes.
    for (int i = 0; i < 6; i++) begin
      rid = (i == 0) ? EXP : 8'($urandom);
      sweep($sformatf("rand%0d_%02h", i, rid), rid, ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, SWEEP - 2)) : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
